// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : audio_pkg
// Purpose  : Shared sample width and soft-mute gain state encoding.
// Revision : 1.0
// ============================================================================
package audio_pkg;

    localparam int SOUND_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_MUTED     = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_PLAY      = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } gain_state_e;

endpackage
`default_nettype wire

// File: rtl/audio_pwm_out_if.sv
`default_nettype none
// ============================================================================
// Module   : audio_pwm_out_if
// Purpose  : Mixer-side sample/enable inputs and PWM pin/status outputs.
// Revision : 1.0
// ============================================================================
interface audio_pwm_out_if #(
    parameter int WIDTH = audio_pkg::SOUND_WIDTH
);
    logic [WIDTH-1:0] sample;
    logic             en;
    logic             pwm_out;
    logic             period_start;
    logic             muted;
    logic [WIDTH-1:0] duty;

    modport master (
        output sample,
        output en,
        input  pwm_out,
        input  period_start,
        input  muted,
        input  duty
    );

    modport slave (
        input  sample,
        input  en,
        output pwm_out,
        output period_start,
        output muted,
        output duty
    );
endinterface
`default_nettype wire

// File: rtl/pwm_core.sv
`default_nettype none
// ============================================================================
// Module   : pwm_core
// Purpose  : Free-running period counter, per-period duty latch and comparator.
// Revision : 1.0
// ============================================================================
module pwm_core #(
    parameter int WIDTH = audio_pkg::SOUND_WIDTH
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic [WIDTH-1:0] duty_next_i,
    output logic                  boundary_o,
    output logic                  pwm_o,
    output logic                  period_start_o,
    output logic [WIDTH-1:0]      duty_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] duty_q;
    logic [WIDTH-1:0] duty_d;
    logic             pwm_q;
    logic             pstart_q;
    logic             w_boundary;

    assign w_boundary = (cnt_q == {WIDTH{1'b1}});
    assign cnt_d      = cnt_q + WIDTH'(1);
    // Duty is frozen for a whole period so mixer changes land only at the wrap.
    assign duty_d     = w_boundary ? duty_next_i : duty_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            duty_q   <= '0;
            pwm_q    <= 1'b0;
            pstart_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            duty_q   <= duty_d;
            pwm_q    <= (cnt_q < duty_q);
            pstart_q <= w_boundary;
        end
    end

    assign boundary_o     = w_boundary;
    assign pwm_o          = pwm_q;
    assign period_start_o = pstart_q;
    assign duty_o         = duty_q;

endmodule
`default_nettype wire

// File: rtl/audio_pwm_out.sv
`default_nettype none
// ============================================================================
// Module   : audio_pwm_out
// Purpose  : Sample-to-PWM output stage with per-period soft-mute gain ramp.
// Revision : 1.0
// ============================================================================
module audio_pwm_out
    import audio_pkg::*;
#(
    parameter int WIDTH     = SOUND_WIDTH,
    parameter int RAMP_STEP = 64
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    audio_pwm_out_if.slave   bus
);

    localparam logic [WIDTH:0] c_full = {1'b1, {WIDTH{1'b0}}};
    localparam logic [WIDTH:0] c_step = (WIDTH+1)'(RAMP_STEP);

    gain_state_e      state_q;
    gain_state_e      state_d;
    logic [WIDTH:0]   gain_q;
    logic [WIDTH:0]   gain_d;
    logic [WIDTH+1:0] w_sum;
    logic [WIDTH:0]   w_inc;
    logic [WIDTH:0]   w_dec;
    logic [WIDTH-1:0] w_duty_next;
    logic             w_boundary;

    assign w_sum = {1'b0, gain_q} + {1'b0, c_step};
    assign w_inc = (w_sum >= {1'b0, c_full}) ? c_full : w_sum[WIDTH:0];
    assign w_dec = (gain_q <= c_step) ? '0 : (gain_q - c_step);

    // Full-width product keeps sample*2^WIDTH exact before the shift.
    assign w_duty_next = WIDTH'(({{(WIDTH+1){1'b0}}, bus.sample} *
                                 {{WIDTH{1'b0}}, gain_q}) >> WIDTH);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_MUTED;
            gain_q  <= '0;
        end else begin
            state_q <= state_d;
            gain_q  <= gain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        if (w_boundary) begin
            case (state_q)
                ST_MUTED: begin
                    if (bus.en) begin
                        gain_d  = w_inc;
                        state_d = (w_inc == c_full) ? ST_PLAY : ST_RAMP_UP;
                    end
                end
                ST_RAMP_UP, ST_RAMP_DOWN: begin
                    if (bus.en) begin
                        gain_d  = w_inc;
                        state_d = (w_inc == c_full) ? ST_PLAY : ST_RAMP_UP;
                    end else begin
                        gain_d  = w_dec;
                        state_d = (w_dec == '0) ? ST_MUTED : ST_RAMP_DOWN;
                    end
                end
                ST_PLAY: begin
                    if (!bus.en) begin
                        gain_d  = w_dec;
                        state_d = (w_dec == '0) ? ST_MUTED : ST_RAMP_DOWN;
                    end
                end
                default: begin
                    gain_d  = '0;
                    state_d = ST_MUTED;
                end
            endcase
        end
    end

    assign bus.muted = (state_q == ST_MUTED);

    pwm_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk            (clk),
        .rst_n          (rst_n),
        .duty_next_i    (w_duty_next),
        .boundary_o     (w_boundary),
        .pwm_o          (bus.pwm_out),
        .period_start_o (bus.period_start),
        .duty_o         (bus.duty)
    );

endmodule
`default_nettype wire

// File: tb/tb_audio_pwm_out.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_pwm_out
// Purpose  : Directed self-checking bench for audio_pwm_out (WIDTH=8, STEP=64).
// Revision : 1.0
// ============================================================================
module tb_audio_pwm_out;
    import audio_pkg::*;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;
    int   hi;

    audio_pwm_out_if #(.WIDTH(8)) bus ();

    audio_pwm_out #(
        .WIDTH     (8),
        .RAMP_STEP (64)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Advance to the negedge of the next cycle with period_start high.
    task automatic sync_period(input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.period_start === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) check({tag, "_timeout"}, 0, 1);
    endtask

    // From a period_start negedge, count high pwm cycles of that period's duty.
    task automatic measure_period(output int high);
        high = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (bus.pwm_out === 1'b1) high++;
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n      = 1'b0;
        bus.en     = 1'b0;
        bus.sample = 8'd0;
        repeat (3) @(negedge clk);

        check("rst_pwm",    int'(bus.pwm_out), 0);
        check("rst_duty",   int'(bus.duty), 0);
        check("rst_pstart", int'(bus.period_start), 0);
        check("rst_muted",  int'(bus.muted), 1);
        check("rst_cnt",    int'(dut.u_core.cnt_q), 0);

        rst_n      = 1'b1;
        bus.en     = 1'b1;
        bus.sample = 8'd128;
        @(negedge clk);
        check("rel_muted",  int'(bus.muted), 1);
        check("rel_pstart", int'(bus.period_start), 0);

        // Unmute ramp: gain 64,128,192,256; duty uses the pre-update gain.
        for (int k = 1; k <= 4; k++) begin
            sync_period("up");
            check($sformatf("up_gain%0d", k), int'(dut.gain_q), 64 * k);
            check($sformatf("up_duty%0d", k), int'(bus.duty), 32 * (k - 1));
            check($sformatf("up_state%0d", k), int'(dut.state_q),
                  (k < 4) ? int'(ST_RAMP_UP) : int'(ST_PLAY));
        end
        sync_period("full");
        check("full_duty", int'(bus.duty), 128);
        measure_period(hi);
        check("high_128", hi, 128);

        // Extreme samples.
        bus.sample = 8'd0;
        measure_period(hi);
        measure_period(hi);
        check("high_0", hi, 0);
        bus.sample = 8'd255;
        measure_period(hi);
        check("max_duty", int'(bus.duty), 255);
        measure_period(hi);
        check("high_255", hi, 255);

        // Mid-period sample change must not disturb the current pulse.
        bus.sample = 8'd200;
        measure_period(hi);
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (bus.pwm_out === 1'b1) hi++;
            if (i == 49) begin
                check("mid_cnt", int'(dut.u_core.cnt_q), 50);
                bus.sample = 8'd10;
            end
        end
        check("mid_high_200", hi, 200);
        measure_period(hi);
        check("mid_high_10", hi, 10);

        // Soft mute from PLAY with full-scale sample.
        bus.sample = 8'd255;
        measure_period(hi);
        bus.en = 1'b0;
        sync_period("dn0");
        check("dn_duty0", int'(bus.duty), 255);
        sync_period("dn1");
        check("dn_duty1", int'(bus.duty), 191);
        sync_period("dn2");
        check("dn_duty2", int'(bus.duty), 127);
        check("dn_muted2", int'(bus.muted), 0);
        sync_period("dn3");
        check("dn_duty3", int'(bus.duty), 63);
        check("dn_muted3", int'(bus.muted), 1);
        sync_period("dn4");
        check("dn_duty4", int'(bus.duty), 0);
        measure_period(hi);
        check("mute_high", hi, 0);

        // Direction reversal at gain 128.
        bus.en = 1'b1;
        sync_period("rv0");
        check("rv_gain64", int'(dut.gain_q), 64);
        sync_period("rv1");
        check("rv_gain128", int'(dut.gain_q), 128);
        bus.en = 1'b0;
        sync_period("rv2");
        check("rv_gain_dn", int'(dut.gain_q), 64);
        check("rv_state_dn", int'(dut.state_q), int'(ST_RAMP_DOWN));
        bus.en = 1'b1;
        sync_period("rv3");
        check("rv_gain_up", int'(dut.gain_q), 128);
        check("rv_state_up", int'(dut.state_q), int'(ST_RAMP_UP));

        // Reset mid-ramp at cnt=100.
        repeat (100) @(negedge clk);
        check("mr_cnt100", int'(dut.u_core.cnt_q), 100);
        rst_n = 1'b0;
        @(negedge clk);
        check("mr_pwm",   int'(bus.pwm_out), 0);
        check("mr_cnt",   int'(dut.u_core.cnt_q), 0);
        check("mr_duty",  int'(bus.duty), 0);
        check("mr_gain",  int'(dut.gain_q), 0);
        check("mr_muted", int'(bus.muted), 1);
        rst_n = 1'b1;
        @(negedge clk);
        check("mr_muted_rel", int'(bus.muted), 1);
        sync_period("mr_up");
        check("mr_restart_gain", int'(dut.gain_q), 64);
        check("mr_restart_state", int'(dut.state_q), int'(ST_RAMP_UP));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/audio_pwm_out.md
# audio_pwm_out

Output stage for the 8-bit mixed `sound` bus produced by the piano mixer. It converts each sample into a single-bit pulse-width-modulated stream for an external RC filter/speaker pin. A per-period soft-mute gain ramp removes clicks when the output is enabled or disabled. The stage holds each sample for one full PWM period, so mid-period changes on the mixer bus never distort the current pulse.

## Interface

Parameters:
- `WIDTH`, 8: sample width; the PWM period is 2^WIDTH clocks.
- `RAMP_STEP`, 64: gain increment or decrement applied per PWM period; range 1..2^WIDTH.

Ports:
- `clk`, in, 1: system clock, the same clock that drives the mixer.
- `rst_n`, in, 1: synchronous, active-low reset.
- `sample`, in, WIDTH: unsigned sample from the mixer `sound` output.
- `en`, in, 1: 1 requests audible output; 0 requests mute.
- `pwm_out`, out, 1: PWM bit to the pin.
- `period_start`, out, 1: one-cycle pulse in the first cycle of each PWM period.
- `muted`, out, 1: high while the gain is fully zero (state MUTED).
- `duty`, out, WIDTH: duty value currently being played; for debug.

## Operation

- **Counter `cnt`**: WIDTH bits, increments every clock and wraps from 2^WIDTH−1 to 0.
- **Period boundary**: the clock edge at which `cnt` = 2^WIDTH−1. At that edge, in one step:
  - `duty` ← (`sample` × `gain`) >> WIDTH, using the `sample` and `gain` values present in that cycle.
  - `gain` updates per the state machine below.
- **Gain**: WIDTH+1 bits, range 0..2^WIDTH. At full gain (2^WIDTH), `duty` equals `sample` exactly.
- **State machine**, evaluated only at period boundaries:
  - MUTED (gain 0):
    - `en`=1 → gain = min(RAMP_STEP, 2^WIDTH); go to RAMP_UP, or directly to PLAY if that value is full.
    - `en`=0 → stay.
  - RAMP_UP:
    - `en`=1 → gain += RAMP_STEP, saturating at 2^WIDTH; on reaching full, go to PLAY.
    - `en`=0 → go to RAMP_DOWN; gain −= RAMP_STEP, saturating at 0; on reaching 0, go to MUTED.
  - PLAY:
    - `en`=0 → gain −= RAMP_STEP; go to RAMP_DOWN, or to MUTED if the result is 0.
    - `en`=1 → stay.
  - RAMP_DOWN:
    - `en`=0 → gain −= RAMP_STEP, saturating at 0; on reaching 0, go to MUTED.
    - `en`=1 → go to RAMP_UP and apply the increment rule.
- **Duty timing**: the `duty` loaded at a boundary uses the pre-update gain. New gain is therefore audible one period after the step.
- **`en` sampling**: `en` toggles between boundaries are ignored. Only the value present at the boundary edge counts.
- **Sample 0** → `pwm_out` stays low for the whole period.
- **Maximum duty 2^WIDTH−1** → high for 2^WIDTH−1 clocks and low for 1 clock. 100 % high is never produced.

## Timing

- **Reset values** (registers loaded when `rst_n`=0 at an edge): `cnt`=0, `gain`=0, state MUTED, `duty`=0, `pwm_out`=0, `period_start`=0.
- **Reset output levels**: `muted` is asserted in the first cycle after reset release, since it decodes state MUTED.
- **`pwm_out`** is registered: `pwm_out`(t+1) = (`cnt`(t) < `duty`(t)). It is high for exactly `duty` consecutive clocks per period, lagging `cnt` by one cycle.
- **`period_start`** is registered from (`cnt` = 2^WIDTH−1). It is high in the cycle where `cnt`=0 and `duty` holds the newly loaded value. It does not pulse in the first cycle after reset.
- **Sample-to-pin latency**: the first affected `pwm_out` cycle is 2 clocks after the boundary edge that samples `sample`.
- **Mute and unmute duration** from a settled state: ceil(2^WIDTH / RAMP_STEP) boundaries.
- **Reset mid-ramp or mid-period**: state is lost and everything returns to reset values on the next edge. No partial pulse completes.

## Structure

- **Shared package `audio_pkg`**:
  - State enum: MUTED, RAMP_UP, PLAY, RAMP_DOWN.
  - Default WIDTH constant, shared with the mixer's `sound` width.
- **Sub-module `pwm_core`**:
  - Owns `cnt`, the `duty` register, the comparator, `pwm_out` and `period_start`.
  - Inputs: the boundary-time duty value.
  - Outputs: the boundary strobe, back to the gain FSM in `audio_pwm_out`.
- **Multiplier**: lives in the top level as a WIDTH × (WIDTH+1) unsigned multiply, truncated by >> WIDTH.

## Test plan

1. **Reset release and unmute**: WIDTH=8, RAMP_STEP=64; release reset, `en`=1, `sample`=128.
   - Gain follows 64, 128, 192, 256 over the first 4 boundaries.
   - Once gain is full, each period has `pwm_out` high for exactly 128 clocks.
2. **Extreme samples** in PLAY:
   - `sample`=0 → 0 high clocks per period.
   - `sample`=255 → 255 high clocks and 1 low clock per period.
3. **Mid-period sample change**: change `sample` 200→10 at `cnt`=50.
   - The current period still has 200 high clocks.
   - The next period has 10.
4. **Soft mute**: in PLAY with `sample`=255, set `en`=0.
   - Successive `duty` values are 255, 191, 127, 63, 0.
   - `muted` rises at the boundary that loads gain 0, and `pwm_out` stays low afterwards.
5. **Direction reversal**: set `en`=0 at gain 128 in RAMP_UP, then `en`=1 one boundary later.
   - Gain follows 128, 64, 128.
   - State follows RAMP_DOWN, then RAMP_UP.
6. **Reset mid-ramp**: assert `rst_n`=0 for 1 cycle at `cnt`=100 during RAMP_UP.
   - Next cycle shows `pwm_out`=0, `cnt`=0, `duty`=0.
   - `muted`=1 while `rst_n` is held low and after release.
   - The ramp restarts from gain 0.
